// File: rtl/noc_pkg.sv
// Shared link-layer constants and header layout for the gate transmitter/receiver pair.
package noc_pkg;

    typedef enum logic [0:0] {StIdle, StSend} tx_state_e;

    function automatic int header_flits(input int fw, input int gw);
        return (1 + 2 * gw + fw - 1) / fw;
    endfunction

    function automatic int header_width(input int fw, input int gw);
        return header_flits(fw, gw) * fw;
    endfunction

    function automatic int request_width(input int fw, input int gw);
        return header_flits(fw, gw) + gw;
    endfunction

    function automatic int beat_count(input int flits, input int gf);
        return (flits + gf - 1) / gf;
    endfunction

    // Header layout (MSB first): {one, vl[GW-1:0], cr[GW-1:0], zero pad}
    function automatic int hdr_one_pos(input int hw);
        return hw - 1;
    endfunction

    function automatic int hdr_vl_msb(input int hw);
        return hw - 2;
    endfunction

    function automatic int hdr_cr_msb(input int hw, input int gw);
        return hw - 2 - gw;
    endfunction

endpackage

// File: rtl/valid_picker.sv
// Picks the next GATE_FOLDS set mask bits strictly below a cursor, highest index first.
module valid_picker
    import noc_pkg::*;
#(
    parameter int unsigned GATE_WIDTH = 4,
    parameter int unsigned GATE_FOLDS = 2,
    localparam int IDX_W = (GATE_WIDTH > 1) ? $clog2(GATE_WIDTH) : 1,
    localparam int CUR_W = $clog2(GATE_WIDTH + 1)
) (
    input  logic [GATE_WIDTH-1:0] mask,
    input  logic [CUR_W-1:0]      cursor,
    output logic [IDX_W-1:0]      idx [GATE_FOLDS],
    output logic [GATE_FOLDS-1:0] none,
    output logic [CUR_W-1:0]      next_cursor
);

    always_comb begin
        int   cur;
        logic found;
        cur = int'(cursor);
        found = 1'b0;
        none = '0;
        for (int s = 0; s < int'(GATE_FOLDS); s++) begin
            idx[s] = '0;
            found = 1'b0;
            for (int g = int'(GATE_WIDTH) - 1; g >= 0; g--) begin
                if (!found && g < cur && mask[g]) begin
                    found = 1'b1;
                    idx[s] = IDX_W'(g);
                end
            end
            none[s] = !found;
            // An exhausted search parks the cursor at 0 so later lanes stay empty.
            cur = found ? int'(idx[s]) : 0;
        end
        next_cursor = CUR_W'(cur);
    end

endmodule

// File: rtl/gate_transmitter.sv
// Serializes one gate packet (header flits, then valid-gate data flits) onto the folded link bus.
module gate_transmitter
    import noc_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH = 8,
    parameter int unsigned GATE_WIDTH = 4,
    parameter int unsigned GATE_FOLDS = 2
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_push,
    output logic                             o_ready,
    input  logic [GATE_WIDTH-1:0]            i_vl,
    input  logic [GATE_WIDTH-1:0]            i_cr,
    input  logic [FLIT_WIDTH-1:0]            i_dt [GATE_WIDTH],
    output logic                             o_w_enable,
    output logic [FLIT_WIDTH*GATE_FOLDS-1:0] o_w_tx
);

    localparam int HF    = header_flits(FLIT_WIDTH, GATE_WIDTH);
    localparam int HW    = header_width(FLIT_WIDTH, GATE_WIDTH);
    localparam int RW    = request_width(FLIT_WIDTH, GATE_WIDTH);
    localparam int GF    = int'(GATE_FOLDS);
    localparam int FW    = int'(FLIT_WIDTH);
    localparam int BW    = $clog2(beat_count(RW, GF) + 1);
    localparam int CUR_W = $clog2(GATE_WIDTH + 1);
    localparam int IDX_W = (GATE_WIDTH > 1) ? $clog2(GATE_WIDTH) : 1;

    tx_state_e               state_q, state_d;
    logic [GATE_WIDTH-1:0]   vl_q, vl_d, cr_q, cr_d;
    logic [FLIT_WIDTH-1:0]   dt_q [GATE_WIDTH];
    logic [FLIT_WIDTH-1:0]   dt_d [GATE_WIDTH];
    logic [BW-1:0]           beat_q, beat_d, beats_q, beats_d;
    // Cursor left after the beat currently on the wire; seeds the following beat.
    logic [CUR_W-1:0]        cur_q, cur_d, cur_start;
    logic [FW*GF-1:0]        tx_q, tx_d;
    logic                    en_q, en_d, ready_q, ready_d;
    logic                    accept, last_beat;

    logic [IDX_W-1:0]        pick_idx [GATE_FOLDS];
    logic [GATE_FOLDS-1:0]   pick_none;
    logic [CUR_W-1:0]        pick_next;
    logic [HW-1:0]           hdr;

    assign accept    = i_push & ready_q;
    assign last_beat = (state_q == StSend) && (beat_q == beats_q - 1'b1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            vl_q    <= '0;
            cr_q    <= '0;
            for (int g = 0; g < int'(GATE_WIDTH); g++) dt_q[g] <= '0;
            beat_q  <= '0;
            beats_q <= '0;
            cur_q   <= '0;
            tx_q    <= '0;
            en_q    <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            vl_q    <= vl_d;
            cr_q    <= cr_d;
            for (int g = 0; g < int'(GATE_WIDTH); g++) dt_q[g] <= dt_d[g];
            beat_q  <= beat_d;
            beats_q <= beats_d;
            cur_q   <= cur_d;
            tx_q    <= tx_d;
            en_q    <= en_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vl_d      = vl_q;
        cr_d      = cr_q;
        dt_d      = dt_q;
        beat_d    = beat_q;
        beats_d   = beats_q;
        cur_start = cur_q;
        if ((state_q == StIdle || last_beat) && accept) begin
            state_d   = StSend;
            vl_d      = i_vl;
            cr_d      = i_cr;
            dt_d      = i_dt;
            beat_d    = '0;
            beats_d   = BW'(beat_count(HF + $countones(i_vl), GF));
            cur_start = CUR_W'(GATE_WIDTH);
        end else if (last_beat) begin
            state_d = StIdle;
        end else if (state_q == StSend) begin
            beat_d = beat_q + 1'b1;
        end
    end

    // Beat contents are computed from next state so every output leaves a flop.
    valid_picker #(
        .GATE_WIDTH (GATE_WIDTH),
        .GATE_FOLDS (GATE_FOLDS)
    ) u_picker (
        .mask        (vl_d),
        .cursor      (cur_start),
        .idx         (pick_idx),
        .none        (pick_none),
        .next_cursor (pick_next)
    );

    always_comb begin
        int base;
        int hcnt;
        logic [FLIT_WIDTH-1:0] flit;
        hdr = '0;
        hdr[hdr_one_pos(HW)] = 1'b1;
        hdr[hdr_vl_msb(HW) -: GATE_WIDTH] = vl_d;
        hdr[hdr_cr_msb(HW, GATE_WIDTH) -: GATE_WIDTH] = cr_d;
        base = int'(beat_d) * GF;
        hcnt = HF - base;
        if (hcnt < 0) hcnt = 0;
        if (hcnt > GF) hcnt = GF;
        tx_d = '0;
        flit = '0;
        for (int l = 0; l < GF; l++) begin
            flit = '0;
            for (int k = 0; k < HF; k++) begin
                if (base + l == k) flit = hdr[HW-1-k*FW -: FW];
            end
            for (int s = 0; s < GF; s++) begin
                if (s + hcnt == l && !pick_none[s]) flit = dt_d[pick_idx[s]];
            end
            tx_d[FW*GF-1-l*FW -: FW] = flit;
        end
        cur_d = pick_next;
        if (hcnt >= GF) begin
            cur_d = cur_start;
        end else if (hcnt > 0) begin
            for (int s = 0; s < GF; s++) begin
                if (s == GF - hcnt - 1) cur_d = pick_none[s] ? '0 : CUR_W'(pick_idx[s]);
            end
        end
        en_d    = (state_d == StSend) && (beat_d == '0);
        ready_d = (state_d == StIdle) || (beat_d == beats_d - 1'b1);
        if (state_d == StIdle) begin
            tx_d  = '0;
            cur_d = '0;
        end
    end

    assign o_w_tx     = tx_q;
    assign o_w_enable = en_q;
    assign o_ready    = ready_q;

endmodule

// File: tb/tb_gate_transmitter.sv
// Directed bench for gate_transmitter with hand-computed beats at default parameters.
module tb_gate_transmitter;

    logic        clk;
    logic        rst;
    logic        push;
    logic        ready;
    logic [3:0]  vl;
    logic [3:0]  cr;
    logic [7:0]  dt [4];
    logic        w_enable;
    logic [15:0] w_tx;

    int n_checks;
    int n_errors;

    gate_transmitter #(
        .FLIT_WIDTH (8),
        .GATE_WIDTH (4),
        .GATE_FOLDS (2)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_push     (push),
        .o_ready    (ready),
        .i_vl       (vl),
        .i_cr       (cr),
        .i_dt       (dt),
        .o_w_enable (w_enable),
        .o_w_tx     (w_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic set_pkt(input logic [3:0] v, input logic [3:0] c,
                           input logic [7:0] d3, input logic [7:0] d2,
                           input logic [7:0] d1, input logic [7:0] d0);
        vl = v;
        cr = c;
        dt[3] = d3;
        dt[2] = d2;
        dt[1] = d1;
        dt[0] = d0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input string tag, input logic [15:0] tx, input logic en,
                               input logic rdy);
        check({tag, "_tx"}, 32'(w_tx), 32'(tx));
        check({tag, "_en"}, 32'(w_enable), 32'(en));
        check({tag, "_rdy"}, 32'(ready), 32'(rdy));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst  = 1'b1;
        push = 1'b0;
        set_pkt(4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        #1;
        expect_beat("reset", 16'h0000, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        expect_beat("idle", 16'h0000, 1'b0, 1'b1);

        // Two valid gates; invalid gate data must not leak onto the bus.
        set_pkt(4'b1010, 4'b0011, 8'hA3, 8'hEE, 8'hA1, 8'hEE);
        push = 1'b1;
        step();
        push = 1'b0;
        expect_beat("p1_b0", 16'hD180, 1'b1, 1'b0);
        step();
        expect_beat("p1_b1", 16'hA3A1, 1'b0, 1'b1);
        step();
        expect_beat("p1_idle", 16'h0000, 1'b0, 1'b1);

        set_pkt(4'b0001, 4'b0000, 8'h11, 8'h22, 8'h33, 8'h5C);
        push = 1'b1;
        step();
        push = 1'b0;
        expect_beat("p2_b0", 16'h8800, 1'b1, 1'b0);
        step();
        expect_beat("p2_b1", 16'h5C00, 1'b0, 1'b1);

        // Header-only packet; credits still go out.
        set_pkt(4'b0000, 4'hF, 8'h99, 8'h99, 8'h99, 8'h99);
        push = 1'b1;
        step();
        push = 1'b0;
        expect_beat("p3_b0", 16'h8780, 1'b1, 1'b1);
        step();
        expect_beat("p3_idle", 16'h0000, 1'b0, 1'b1);

        // Full packet with push held: re-accept on the last beat, zero bubble.
        set_pkt(4'hF, 4'b0101, 8'hD3, 8'hD2, 8'hD1, 8'hD0);
        push = 1'b1;
        step();
        set_pkt(4'b0100, 4'b1000, 8'h01, 8'h7E, 8'h02, 8'h03);
        expect_beat("p4_b0", 16'hFA80, 1'b1, 1'b0);
        step();
        expect_beat("p4_b1", 16'hD3D2, 1'b0, 1'b0);
        step();
        expect_beat("p4_b2", 16'hD1D0, 1'b0, 1'b1);
        step();
        push = 1'b0;
        expect_beat("p5_b0", 16'hA400, 1'b1, 1'b0);
        step();
        expect_beat("p5_b1", 16'h7E00, 1'b0, 1'b1);
        step();
        expect_beat("p5_idle", 16'h0000, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a three-beat packet.
        set_pkt(4'hF, 4'b0101, 8'hD3, 8'hD2, 8'hD1, 8'hD0);
        push = 1'b1;
        step();
        push = 1'b0;
        expect_beat("p6_b0", 16'hFA80, 1'b1, 1'b0);
        step();
        expect_beat("p6_b1", 16'hD3D2, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        expect_beat("midrst", 16'h0000, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        step();
        expect_beat("postrst_idle", 16'h0000, 1'b0, 1'b1);
        set_pkt(4'b1010, 4'b0011, 8'hA3, 8'h44, 8'hA1, 8'h55);
        push = 1'b1;
        step();
        push = 1'b0;
        expect_beat("p7_b0", 16'hD180, 1'b1, 1'b0);
        step();
        expect_beat("p7_b1", 16'hA3A1, 1'b0, 1'b1);
        step();
        expect_beat("p7_idle", 16'h0000, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gate_transmitter.md
# gate_transmitter

Upstream partner of the receiver stage. Accepts one gate packet per handshake (valids, credits, one data flit per gate), then serializes it onto the folded link bus, `GATE_FOLDS` flits per beat. A packet consists of header flits followed by data flits for valid gates only. Lane and flit order are exactly what the receiver's scheduler and async FIFO reassemble. The block sits in the sending partition's link clock domain and drives the inter-partition wires directly.

## Interface
- `FLIT_WIDTH`, default 8: bits per flit.
- `GATE_WIDTH`, default 4: number of gates (data flit slots) per packet.
- `GATE_FOLDS`, default 2: flits per link beat.
- Derived constants:
  - `HEADER_SIZE` = 1 + 2·`GATE_WIDTH`.
  - `HEADER_FLITS` = ceil(`HEADER_SIZE`/`FLIT_WIDTH`).
  - `HEADER_WIDTH` = `HEADER_FLITS`·`FLIT_WIDTH`.
  - `REQUEST_WIDTH` = `HEADER_FLITS` + `GATE_WIDTH`.
- `i_clk`  in  1  sole clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_push`  in  1  packet offer; accepted when `i_push & o_ready`.
- `o_ready`  out  1  block can accept a packet this cycle.
- `i_vl`  in  `GATE_WIDTH`  per-gate valid.
- `i_cr`  in  `GATE_WIDTH`  per-gate credit return.
- `i_dt`  in  `FLIT_WIDTH` × [`GATE_WIDTH`] (unpacked)  per-gate data flit.
- `o_w_enable`  out  1  high on the first (header) beat of each packet only.
- `o_w_tx`  out  `FLIT_WIDTH`·`GATE_FOLDS`  link beat; lane 0 = bus MSB flit.

## Operation
- On accept, register `i_vl`, `i_cr`, `i_dt` into a packet buffer. Inputs are don't-care otherwise.
- Flat header (`HEADER_WIDTH` bits, MSB first) = {1'b1, vl[GW-1:0], cr[GW-1:0], zero pad}. Header flit k (k=0 first) = flat header bits [HEADER_WIDTH-1-k·FW -: FW].
- Flit sequence: header flits 0..`HEADER_FLITS`-1, then data flits of valid gates in descending gate index (GW-1 down to 0). Invalid gates are skipped.
- N = `HEADER_FLITS` + popcount(vl). Beats = ceil(N/`GATE_FOLDS`).
- Sequence flits fill lanes in order: lane 0 (bits [FW·GF-1 -: FW]) first, then lane 1, and so on. Unused lanes in the last beat are zero.
- FSM:
  - IDLE: `o_ready`=1, bus zero.
  - Accept → SEND.
  - SEND: one beat per cycle; a gate cursor advances past the next `GATE_FOLDS` valid gates each beat.
  - On the last beat: if a new accept occurs, reload and stay in SEND; else → IDLE.
- `o_ready` = IDLE | (SEND & last beat).
- All-zero vl still sends a header-only packet. Credits must always propagate.
- Idle bus is all zero, so the MSB (one-flag) is 0 whenever no header beat is on the wire.

## Timing
- Accept at cycle t → header beat on `o_w_tx` with `o_w_enable`=1 at t+1. Remaining beats follow at t+2 … t+Beats with no gaps.
- Back-to-back packets: next header beat appears the cycle after the previous last beat. Zero bubble.
- All outputs are registered.
- Reset (async, any cycle, including mid-packet): FSM→IDLE, `o_w_tx`=0, `o_w_enable`=0, `o_ready`=1 after release, buffer cleared. A partially sent packet is abandoned. The receiver sees no further beats.
- Cursor width: $clog2(`GATE_WIDTH`+1). Beat counter width: $clog2(ceil(`REQUEST_WIDTH`/`GATE_FOLDS`)+1).

## Structure
- Shared package `noc_pkg`:
  - functions for `HEADER_FLITS`, `HEADER_WIDTH`, `REQUEST_WIDTH`, beat count;
  - header-layout bit offsets, shared with the receiver.
- One sub-module `valid_picker`: combinational. Given a mask and a start cursor, returns the next `GATE_FOLDS` set indices (descending) plus per-lane none flags and the next cursor.

## Test plan
All scenarios use defaults (FW=8, GW=4, GF=2).
- vl=4'b1010, cr=4'b0011, dt[3]=A3, dt[1]=A1 → beat0 16'hD180 with `o_w_enable`=1; beat1 16'hA3A1; `o_ready` high during beat1.
- vl=4'b0001, cr=0, dt[0]=5C → 16'h8800, then 16'h5C00.
- vl=0, cr=4'hF → single beat 16'h8780; `o_ready` stays high.
- vl=4'hF, dt={D3,D2,D1,D0} → 3 beats: header pair, 16'hD3D2, 16'hD1D0. A push held high re-accepts on beat 3; the next header appears immediately after.
- `i_rst` pulsed mid-beat-1 of a 3-beat packet → bus 0 immediately; `o_ready`=1; next push sends a clean packet.
- Random vl/cr/dt stream looped into the receiver → `o_r_vl`/`o_r_cr` and valid data match the sent values.
